hs_fifo_param: RTL and testbench
================================

Name: hs_fifo_param

Overview:
Parametrised successor to the team's handshake FIFO, generalised in WIDTH and DEPTH. DEPTH need not be a power of two.
- Keeps the same 4-phase tx_rdy/tx_done and rx_rdy/rx_done handshakes.
- Adds simultaneous push/pop, an occupancy level output, programmable almost-full/almost-empty flags and a synchronous flush.
- Sits between a producer and a consumer that each run the 4-phase protocol on the same clock.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 5, number of entries; any value >= 2.
- AF_THRESH, DEPTH-1, almost_full asserts when level >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents; active high.
- tx_rdy  in  1  producer has in_data valid; held high until tx_done is seen.
- tx_done  out  1  FIFO has stored the word; held high until tx_rdy falls.
- in_data  in  WIDTH  write data.
- rx_rdy  out  1  out_data is valid; held high until rx_done is seen.
- rx_done  in  1  consumer has taken out_data; held high until rx_rdy falls.
- out_data  out  WIDTH  read data, registered.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AF_THRESH.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  $clog2(DEPTH+1)  current occupancy, registered.

Behaviour:
- Reset (rst_n low, asynchronous): front=back=0, level=0, tx_done=0, rx_rdy=0, out_data=0, both FSMs idle.
  - Flag outputs after reset: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0).
  - Buffer contents are not reset.
- Pointers front/back are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0; wrap is explicit, never a natural overflow.
- TX FSM:
  - TX_IDLE: if tx_rdy && !full && !flush, then buffer[back]<=in_data, back++, incr=1, tx_done<=1, go to TX_ACK.
  - TX_IDLE with full or flush: word is not accepted; tx_done stays 0 and tx_rdy simply stays pending.
  - TX_ACK: accept nothing. When tx_rdy==0, tx_done<=0 and go to TX_IDLE.
  - Minimum one write per 3 clocks (accept, ack, release).
- RX FSM:
  - RX_IDLE: if level!=0 && !flush, then out_data<=buffer[front], rx_rdy<=1, go to RX_OFFER.
  - RX_OFFER: if rx_done, then front++, decr=1, rx_rdy<=0, go to RX_WAIT.
  - RX_WAIT: when rx_done==0, go to RX_IDLE.
- level update is registered:
  - incr&!decr gives +1; decr&!incr gives -1; both asserted leaves level unchanged.
  - Flags are combinational from registered level.
- Latency into an empty FIFO: accept edge N; level=1 after N; rx_rdy=1 after edge N+1.
- A push and a pop in the same cycle are legal at any level, including full, where TX is blocked anyway.
- Flush (synchronous, priority over push/pop):
  - front=back=0, level=0, rx_rdy<=0, out_data holds its value.
  - RX goes to RX_WAIT if rx_done is high, else to RX_IDLE.
  - A TX_ACK in progress completes normally; no word is accepted in the flush cycle.
- Reset asserted mid-handshake clears tx_done/rx_rdy immediately; the partner must restart its handshake.

Optional Feature:
- Macro HS_FIFO_PEAK_EN.
- When defined:
  - Adds output peak_level, width $clog2(DEPTH+1).
  - peak_level is a registered high-watermark of level, updated the cycle after level exceeds it.
  - Cleared to 0 by rst_n and by flush.
- When undefined: the port and its register are absent and all other behaviour is identical.

Test Plan:
- DEPTH=5, WIDTH=8, fill: 5 back-to-back 4-phase writes of 0x11..0x55 -> tx_done pulses each time; level 1..5; almost_full at level 4; full=1 after the 5th write; a 6th tx_rdy gets no tx_done while full.
- Drain: 5 reads -> out_data 0x11,0x22,0x33,0x44,0x55 in order; empty=1 and rx_rdy=0 after the last rx_done.
- Wrap: run 12 write/read pairs at level 2-3 -> pointers wrap 4->0 twice; data order preserved; level never exceeds 5.
- Simultaneous: at level 3, push accept and pop complete on the same edge -> level stays 3; next pop returns the oldest word.
- Flush/reset: with level=4, flush for 1 cycle -> level=0, empty=1, rx_rdy=0 next cycle. rst_n pulsed low mid TX_ACK -> tx_done=0 asynchronously.
- With HS_FIFO_PEAK_EN: fill to 4, drain to 1 -> peak_level=4; flush -> 0.

Source files
------------

// File: rtl/hs_fifo_param_if.sv
// Handshake bundle between a producer/consumer pair and hs_fifo_param.
// master: the side running the producer and consumer (drives tx_rdy, in_data, rx_done).
// slave:  the FIFO (drives tx_done, rx_rdy, out_data).
interface hs_fifo_param_if #(
  parameter int WIDTH = 8
);
  logic             tx_rdy;
  logic             tx_done;
  logic [WIDTH-1:0] in_data;
  logic             rx_rdy;
  logic             rx_done;
  logic [WIDTH-1:0] out_data;

  modport master (output tx_rdy, in_data, rx_done,
                  input  tx_done, rx_rdy, out_data);
  modport slave  (input  tx_rdy, in_data, rx_done,
                  output tx_done, rx_rdy, out_data);
endinterface

// File: rtl/hs_fifo_param.sv
// hs_fifo_param: WIDTH x DEPTH FIFO with 4-phase handshakes on both sides.
// The push and pop sides can complete on the same edge. The FIFO provides a
// registered level, level-derived flags and a synchronous flush.
// DEPTH may be any value >= 2. Pointers wrap explicitly at DEPTH-1.
// Optional: define HS_FIFO_PEAK_EN to add peak_level, a high-watermark of level.
module hs_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 5,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  hs_fifo_param_if.slave               bus,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef HS_FIFO_PEAK_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   peak_level
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic       {TX_IDLE, TX_ACK}            tx_st_t;
  typedef enum logic [1:0] {RX_IDLE, RX_OFFER, RX_WAIT} rx_st_t;

  tx_st_t tx_st, tx_nxt;
  rx_st_t rx_st, rx_nxt;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               front, back;
  logic                        push, pop, load;

  // Pointer advance with an explicit wrap, so a non-power-of-two DEPTH is handled correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Flags are decoded from the registered level only.
  assign empty        = (level == '0);
  assign full         = (int'(level) == DEPTH);
  assign almost_full  = (int'(level) >= AF_THRESH);
  assign almost_empty = (int'(level) <= AE_THRESH);

  // Producer side: accept one word per handshake, then wait for tx_rdy to drop.
  // A flush or a full FIFO blocks acceptance, so tx_rdy simply stays pending.
  always_comb begin
    tx_nxt = tx_st;
    push   = 1'b0;
    unique case (tx_st)
      TX_IDLE: if (bus.tx_rdy && !full && !flush) begin
        push   = 1'b1;
        tx_nxt = TX_ACK;
      end
      TX_ACK:  if (!bus.tx_rdy) tx_nxt = TX_IDLE;
      default: tx_nxt = TX_IDLE;
    endcase
  end

  // Consumer side: offer the head word, pop on rx_done, then wait for rx_done to drop.
  // A flush withdraws any offer. If rx_done is still high, the FSM parks in RX_WAIT
  // so the stale acknowledge is not taken as a pop.
  always_comb begin
    rx_nxt = rx_st;
    pop    = 1'b0;
    load   = 1'b0;
    if (flush) begin
      rx_nxt = bus.rx_done ? RX_WAIT : RX_IDLE;
    end else begin
      unique case (rx_st)
        RX_IDLE:  if (level != '0) begin
          load   = 1'b1;
          rx_nxt = RX_OFFER;
        end
        RX_OFFER: if (bus.rx_done) begin
          pop    = 1'b1;
          rx_nxt = RX_WAIT;
        end
        RX_WAIT:  if (!bus.rx_done) rx_nxt = RX_IDLE;
        default:  rx_nxt = RX_IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only written on an accepted push.
  always_ff @(posedge clk) begin
    if (push) mem[back] <= bus.in_data;
  end

  // State, handshake outputs, pointers and occupancy. Flush has priority over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st        <= TX_IDLE;
      rx_st        <= RX_IDLE;
      bus.tx_done  <= 1'b0;
      bus.rx_rdy   <= 1'b0;
      bus.out_data <= '0;
      front        <= '0;
      back         <= '0;
      level        <= '0;
    end else begin
      tx_st       <= tx_nxt;
      rx_st       <= rx_nxt;
      bus.tx_done <= (tx_nxt == TX_ACK);
      bus.rx_rdy  <= (rx_nxt == RX_OFFER);
      if (load) bus.out_data <= mem[front];
      if (flush) begin
        front <= '0;
        back  <= '0;
        level <= '0;
      end else begin
        if (push) back  <= ptr_inc(back);
        if (pop)  front <= ptr_inc(front);
        unique case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

`ifdef HS_FIFO_PEAK_EN
  // High-watermark of level, one cycle behind; cleared by reset and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  peak_level <= '0;
    else if (flush)              peak_level <= '0;
    else if (level > peak_level) peak_level <= level;
  end
`endif

endmodule

// File: tb/tb_hs_fifo_param.sv
// Directed bench for hs_fifo_param (WIDTH=8, DEPTH=5). A queue model follows the
// observable handshakes and is compared with the DUT on every falling edge.
// Literal expectations in the directed sequence pin the model.
module tb_hs_fifo_param;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       empty, full, almost_full, almost_empty;
  logic [2:0] level;
`ifdef HS_FIFO_PEAK_EN
  logic [2:0] peak_level;
`endif

  int tests = 0;
  int fails = 0;

  hs_fifo_param_if #(.WIDTH(8)) bus ();

  hs_fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level)
`ifdef HS_FIFO_PEAK_EN
    ,
    .peak_level   (peak_level)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Queue model: a rising tx_done means the word offered at that edge was stored.
  // A falling rx_rdy that is not caused by a flush means the head word was consumed.
  initial begin : cmp
    logic [7:0] q[$];
    logic       ptd, prr, fl;
    logic [7:0] din;
    int         n, pk, prevn;
    ptd = 0; prr = 0; pk = 0; prevn = 0;
    forever begin
      @(posedge clk);
      fl  = flush;
      din = bus.in_data;
      @(negedge clk);
      if (!rst_n) begin
        q.delete(); ptd = 0; prr = 0; pk = 0; prevn = 0;
        chk("rst tx_done", int'(bus.tx_done), 0);
        chk("rst rx_rdy", int'(bus.rx_rdy), 0);
        chk("rst level", int'(level), 0);
        chk("rst empty", int'(empty), 1);
        chk("rst out_data", int'(bus.out_data), 0);
        continue;
      end
      if (fl) begin
        q.delete();
        pk = 0;
      end else begin
        if (prr && !bus.rx_rdy && q.size() > 0) void'(q.pop_front());
        if (!ptd && bus.tx_done) q.push_back(din);
        if (prevn > pk) pk = prevn;
      end
      n = q.size();
      chk("level", int'(level), n);
      chk("empty", int'(empty), int'(n == 0));
      chk("full", int'(full), int'(n == DEPTH));
      chk("almost_full", int'(almost_full), int'(n >= AF));
      chk("almost_empty", int'(almost_empty), int'(n <= AE));
      if (bus.rx_rdy) begin
        if (n == 0) chk("offer while model empty", int'(bus.rx_rdy), 0);
        else        chk("out_data head", int'(bus.out_data), int'(q[0]));
      end
`ifdef HS_FIFO_PEAK_EN
      chk("peak_level", int'(peak_level), pk);
`endif
      prevn = n;
      ptd   = bus.tx_done;
      prr   = bus.rx_rdy;
    end
  end

  // Full 4-phase write; starts and ends half a cycle clear of the rising edge.
  task automatic push(input logic [7:0] d);
    int k;
    @(posedge clk); #1;
    bus.in_data = d;
    bus.tx_rdy  = 1'b1;
    k = 0;
    while (!bus.tx_done && k < 20) begin @(posedge clk); #1; k++; end
    chk("tx_done ack", int'(bus.tx_done), 1);
    bus.tx_rdy = 1'b0;
    k = 0;
    while (bus.tx_done && k < 20) begin @(posedge clk); #1; k++; end
    chk("tx_done release", int'(bus.tx_done), 0);
  endtask

  // Full 4-phase read.
  task automatic pop(output logic [7:0] d);
    int k;
    k = 0;
    while (!bus.rx_rdy && k < 20) begin @(posedge clk); #1; k++; end
    chk("rx_rdy offer", int'(bus.rx_rdy), 1);
    d = bus.out_data;
    bus.rx_done = 1'b1;
    k = 0;
    while (bus.rx_rdy && k < 20) begin @(posedge clk); #1; k++; end
    chk("rx_rdy release", int'(bus.rx_rdy), 0);
    bus.rx_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_offer();
    int k;
    k = 0;
    while (!bus.rx_rdy && k < 20) begin @(posedge clk); #1; k++; end
    chk("rx_rdy wait", int'(bus.rx_rdy), 1);
  endtask

  initial begin : main
    logic [7:0] d;
    rst_n = 1'b0; flush = 1'b0;
    bus.tx_rdy = 1'b0; bus.rx_done = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset almost_full", int'(almost_full), 0);
    chk("reset almost_empty", int'(almost_empty), 1);
    chk("reset full", int'(full), 0);
    rst_n = 1'b1;

    // Fill with 0x11..0x55.
    for (int i = 0; i < 5; i++) begin
      push(8'(8'h11 * (i + 1)));
      chk("fill level", int'(level), i + 1);
      chk("fill almost_full", int'(almost_full), int'(i >= 3));
      chk("fill full", int'(full), int'(i == 4));
    end

    // A sixth write must stay pending while full.
    bus.in_data = 8'h66;
    bus.tx_rdy  = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no ack when full", int'(bus.tx_done), 0);
    bus.tx_rdy = 1'b0;
    @(posedge clk); #1;

    // Drain in order.
    for (int i = 0; i < 5; i++) begin
      pop(d);
      chk("drain data", int'(d), int'(8'(8'h11 * (i + 1))));
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drained empty", int'(empty), 1);
    chk("drained rx_rdy", int'(bus.rx_rdy), 0);

    // Wrap: hold level at 2..3 for 12 write/read pairs (14 writes wrap back twice).
    push(8'hA0);
    push(8'hA1);
    for (int i = 0; i < 12; i++) begin
      push(8'(8'hA2 + i));
      chk("wrap level<=3", int'(level <= 3), 1);
      pop(d);
      chk("wrap data", int'(d), int'(8'(8'hA0 + i)));
    end
    chk("wrap end level", int'(level), 2);

    // Simultaneous push accept and pop completion at level 3.
    push(8'hAE);
    chk("pre-simul level", int'(level), 3);
    wait_offer();
    chk("simul head", int'(bus.out_data), 8'hAC);
    bus.in_data = 8'hC3; bus.tx_rdy = 1'b1; bus.rx_done = 1'b1;
    @(posedge clk); #1;
    chk("simul level", int'(level), 3);
    chk("simul tx_done", int'(bus.tx_done), 1);
    chk("simul rx_rdy", int'(bus.rx_rdy), 0);
    bus.tx_rdy = 1'b0; bus.rx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pop(d);
    chk("post-simul oldest", int'(d), 8'hAD);

    // Flush at level 4.
    push(8'hD1);
    push(8'hD2);
    chk("pre-flush level", int'(level), 4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush level", int'(level), 0);
    chk("flush empty", int'(empty), 1);
    chk("flush rx_rdy", int'(bus.rx_rdy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("post-flush no offer", int'(bus.rx_rdy), 0);

    // Reset during TX_ACK clears tx_done without a clock edge.
    bus.in_data = 8'h5A; bus.tx_rdy = 1'b1;
    begin
      int k;
      k = 0;
      while (!bus.tx_done && k < 20) begin @(posedge clk); #1; k++; end
    end
    chk("pre-reset tx_done", int'(bus.tx_done), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async tx_done", int'(bus.tx_done), 0);
    chk("async level", int'(level), 0);
    bus.tx_rdy = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset: the FIFO works again from empty.
    push(8'h77);
    pop(d);
    chk("post-reset data", int'(d), 8'h77);

`ifdef HS_FIFO_PEAK_EN
    // High-watermark: fill to 4, drain to 1, then flush.
    for (int i = 0; i < 4; i++) push(8'(8'hE0 + i));
    for (int i = 0; i < 3; i++) pop(d);
    repeat (2) @(posedge clk);
    #1;
    chk("peak after drain", int'(peak_level), 4);
    chk("level after drain", int'(level), 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("peak after flush", int'(peak_level), 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
